// File: rtl/partition_error_scanner.sv
// Exhaustive sweep sequencer and error scorer for one exact/approximate adder partition pair.
// Optional mean-error-distance accumulator enabled by defining PARTITION_SCANNER_MED_EN.
module partition_error_scanner #(
  parameter  int NUM_IN  = 9,
  parameter  int NUM_OUT = 5,
  parameter  int ERR_W   = 16,
  localparam int HAM_W   = $clog2(NUM_OUT + 1),
  localparam int MED_W   = ERR_W + NUM_OUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [NUM_IN-1:0]  vec_out,
  input  logic [NUM_OUT-1:0] exact_po,
  input  logic [NUM_OUT-1:0] approx_po,
  output logic               busy,
  output logic               done,
  output logic               result_valid,
  output logic [ERR_W-1:0]   err_count,
  output logic [ERR_W-1:0]   ham_sum,
  output logic [HAM_W-1:0]   max_ham,
  output logic [MED_W-1:0]   med_sum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IN-1:0]  vec_q, vec_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ERR_W-1:0]   ham_sum_q, ham_sum_d;
  logic [HAM_W-1:0]   max_ham_q, max_ham_d;
  logic               valid_q, valid_d;

  logic [NUM_OUT-1:0] diff;
  logic [HAM_W-1:0]   ham;
  logic [ERR_W:0]     ham_sum_ext;

  // Per-vector Hamming distance between the two partition responses.
  always_comb begin
    diff = exact_po ^ approx_po;
    ham  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      ham = ham + HAM_W'(diff[i]);
    end
    ham_sum_ext = {1'b0, ham_sum_q} + (ERR_W+1)'(ham);
  end

`ifdef PARTITION_SCANNER_MED_EN
  logic [MED_W-1:0]   med_q, med_d;
  logic [NUM_OUT-1:0] abs_diff;
  logic [MED_W:0]     med_ext;

  always_comb begin
    abs_diff = (exact_po > approx_po) ? (exact_po - approx_po) : (approx_po - exact_po);
    med_ext  = {1'b0, med_q} + (MED_W+1)'(abs_diff);
    med_d    = med_q;
    case (state_q)
      S_IDLE: if (start) med_d = '0;
      S_RUN:  if (!abort) med_d = med_ext[MED_W] ? '1 : med_ext[MED_W-1:0];
      default: med_d = med_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) med_q <= '0;
    else        med_q <= med_d;
  end

  assign med_sum = med_q;
`else
  assign med_sum = '0;
`endif

  // NOTE: combinational blocks use blocking '=' and assign every target a
  // default first, so no path can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    err_d     = err_q;
    ham_sum_d = ham_sum_q;
    max_ham_d = max_ham_q;
    valid_d   = valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          vec_d     = '0;
          err_d     = '0;
          ham_sum_d = '0;
          max_ham_d = '0;
          valid_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (abort) begin
          // The vector presented on the abort cycle is deliberately dropped.
          state_d = S_IDLE;
          vec_d   = '0;
        end else begin
          if ((ham != '0) && (err_q != '1)) err_d = err_q + 1'b1;
          ham_sum_d = ham_sum_ext[ERR_W] ? '1 : ham_sum_ext[ERR_W-1:0];
          if (ham > max_ham_q) max_ham_d = ham;
          if (vec_q == '1) begin
            state_d = S_FIN;
            valid_d = 1'b1;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      err_q     <= '0;
      ham_sum_q <= '0;
      max_ham_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
      ham_sum_q <= ham_sum_d;
      max_ham_q <= max_ham_d;
      valid_q   <= valid_d;
    end
  end

  assign vec_out      = vec_q;
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_FIN);
  assign result_valid = valid_q;
  assign err_count    = err_q;
  assign ham_sum      = ham_sum_q;
  assign max_ham      = max_ham_q;

endmodule
